// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache geometry, frame layout and FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_IDX_W = 4;
  localparam int ICACHE_TAG_W = 26;

  // One cache frame: a single instruction word with its tag and valid bit.
  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-frame instruction cache between the fetch port
// and the memory controller's instruction port. Hits are served in the same
// cycle; a miss performs a single-word fill and stalls fetch until it lands.
module icache_direct
  import cpu_types_pkg::*;
#(
  parameter int IDX_W = ICACHE_IDX_W,
  parameter int TAG_W = ICACHE_TAG_W   // must equal 32 - IDX_W - 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int FRAMES = 1 << IDX_W;

  // Valid bits are reset; tag and data are only meaningful once valid is set.
  logic [FRAMES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q  [FRAMES];
  word_t             data_q [FRAMES];

  icache_state_t state, state_next;
  word_t         miss_addr;

  logic [TAG_W-1:0] req_tag, fill_tag;
  logic [IDX_W-1:0] req_idx, fill_idx;
  icache_frame_t    lookup;
  logic             hit;
  logic             miss_capture;
  logic             fill_done;
  logic             unused_offset;

  assign req_tag       = imemaddr[31 -: TAG_W];
  assign req_idx       = imemaddr[IDX_W+1:2];
  assign fill_tag      = miss_addr[31 -: TAG_W];
  assign fill_idx      = miss_addr[IDX_W+1:2];
  assign unused_offset = ^imemaddr[1:0];

  // Read the frame selected by the current fetch address.
  always_comb begin
    lookup       = '0;
    lookup.valid = valid_q[req_idx];
    lookup.tag   = tag_q[req_idx];
    lookup.data  = data_q[req_idx];
  end

  // Next-state and output decode; a miss stalls fetch until the fill returns.
  always_comb begin
    state_next   = state;
    hit          = 1'b0;
    ihit         = 1'b0;
    imemload     = '0;
    iREN         = 1'b0;
    iaddr        = '0;
    miss_capture = 1'b0;
    fill_done    = 1'b0;
    case (state)
      IDLE: begin
        hit      = imemREN & lookup.valid & (lookup.tag == req_tag);
        ihit     = hit;
        imemload = hit ? lookup.data : '0;
        if (imemREN && !hit) begin
          miss_capture = 1'b1;
          state_next   = FILL;
        end
      end
      FILL: begin
        // The fill always completes to the captured address, even if the
        // datapath redirects or drops its request meanwhile.
        iREN  = 1'b1;
        iaddr = miss_addr;
        if (!iwait) begin
          fill_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and miss address capture.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= '0;
    end else begin
      state <= state_next;
      if (miss_capture) begin
        miss_addr <= {imemaddr[31:2], 2'b00};
      end
    end
  end

  // Valid bits: cleared on reset, set when a fill completes.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
    end else if (fill_done) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data storage written by the completing fill.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios followed by
// random fetches, all checked against a frame-level reference model.
module tb_icache_direct;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int tests;
  int fails;

  // Reference model: per-index valid flag, tag and stored word.
  bit          mv [16];
  logic [25:0] mt [16];
  logic [31:0] md [16];

  icache_direct dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % 16);
  endfunction

  function automatic logic [25:0] tag_of(input logic [31:0] a);
    logic [31:0] t;
    t = a >> 6;
    return t[25:0];
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return mv[idx_of(a)] && (mt[idx_of(a)] == tag_of(a));
  endfunction

  function automatic void model_fill(input logic [31:0] a, input logic [31:0] d);
    mv[idx_of(a)] = 1'b1;
    mt[idx_of(a)] = tag_of(a);
    md[idx_of(a)] = d;
  endfunction

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Enter at just after a rising edge; returns at just after a rising edge.
  // On a miss, memory holds iwait high for nw cycles, then returns d.
  task automatic fetch(input logic [31:0] a, input int nw, input logic [31:0] d);
    bit exp_hit;
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b1;
    iload    = $urandom;
    exp_hit  = model_hit(a);
    @(negedge CLK);
    chk("lookup_hit", {31'd0, ihit}, {31'd0, exp_hit});
    chk("idle_iren", {31'd0, iREN}, 32'd0);
    if (exp_hit) begin
      chk("hit_load", imemload, md[idx_of(a)]);
      @(posedge CLK); #1;
      return;
    end
    @(posedge CLK); #1;
    for (int k = 0; k <= nw; k++) begin
      iwait = (k < nw);
      iload = (k == nw) ? d : $urandom;
      @(negedge CLK);
      chk("fill_iren", {31'd0, iREN}, 32'd1);
      chk("fill_iaddr", iaddr, {a[31:2], 2'b00});
      chk("fill_ihit", {31'd0, ihit}, 32'd0);
      @(posedge CLK); #1;
    end
    model_fill(a, d);
    iwait = 1'b1;
    @(negedge CLK);
    chk("after_fill_hit", {31'd0, ihit}, 32'd1);
    chk("after_fill_load", imemload, d);
    chk("after_fill_iren", {31'd0, iREN}, 32'd0);
    @(posedge CLK); #1;
  endtask

  initial begin
    logic [31:0] a;
    tests = 0;
    fails = 0;
    for (int i = 0; i < 16; i++) begin
      mv[i] = 1'b0;
      mt[i] = '0;
      md[i] = '0;
    end

    // Reset state, with a fetch request already present.
    nRST     = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    iload    = 32'h0;
    #3;
    chk("rst_ihit", {31'd0, ihit}, 32'd0);
    chk("rst_iren", {31'd0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    // First fetch misses; memory waits 2 cycles then returns the word.
    fetch(32'h0000_0000, 2, 32'h3C01_0001);
    // Immediate re-fetch hits.
    fetch(32'h0000_0000, 0, 32'h0);

    // Aliasing at index 0.
    fetch(32'h0000_0040, 1, 32'hDEAD_BEEF);
    fetch(32'h0000_0000, 1, 32'h3C01_0001);

    // Fill 16 sequential words, then re-read all as back-to-back hits.
    for (int i = 0; i < 16; i++) begin
      a = 32'(i * 4);
      fetch(a, i % 3, memval(a));
    end
    for (int i = 0; i < 16; i++) begin
      a = 32'(i * 4);
      fetch(a, 0, 32'h0);
    end

    // Redirect during a fill: fill completes to 0x100, then 0x200 misses.
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0100;
    iwait    = 1'b1;
    @(negedge CLK);
    chk("redir_miss", {31'd0, ihit}, {31'd0, model_hit(32'h100)});
    @(posedge CLK); #1;
    imemaddr = 32'h0000_0200;
    @(negedge CLK);
    chk("redir_iaddr0", iaddr, 32'h0000_0100);
    chk("redir_iren0", {31'd0, iREN}, 32'd1);
    @(posedge CLK); #1;
    iwait = 1'b0;
    iload = 32'h1111_0100;
    @(negedge CLK);
    chk("redir_iaddr1", iaddr, 32'h0000_0100);
    @(posedge CLK); #1;
    model_fill(32'h100, 32'h1111_0100);
    fetch(32'h0000_0200, 0, 32'h2222_0200);

    // Request dropped during a fill: fill still lands and later hits.
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0300;
    iwait    = 1'b1;
    @(negedge CLK);
    chk("drop_miss", {31'd0, ihit}, {31'd0, model_hit(32'h300)});
    @(posedge CLK); #1;
    imemREN  = 1'b0;
    imemaddr = 32'h0000_1234;
    @(negedge CLK);
    chk("drop_iaddr", iaddr, 32'h0000_0300);
    @(posedge CLK); #1;
    iwait = 1'b0;
    iload = 32'h3333_0300;
    @(posedge CLK); #1;
    model_fill(32'h300, 32'h3333_0300);
    iwait = 1'b1;
    @(negedge CLK);
    chk("noreq_ihit", {31'd0, ihit}, 32'd0);
    chk("noreq_load", imemload, 32'd0);
    chk("noreq_iren", {31'd0, iREN}, 32'd0);
    @(posedge CLK); #1;
    fetch(32'h0000_0300, 0, 32'h0);

    // Reset in the middle of a fill: iREN drops at once, nothing is written.
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0080;
    iwait    = 1'b1;
    @(negedge CLK);
    chk("rstfill_miss", {31'd0, ihit}, {31'd0, model_hit(32'h80)});
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rstfill_iren_pre", {31'd0, iREN}, 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("rstfill_iren", {31'd0, iREN}, 32'd0);
    chk("rstfill_iaddr", iaddr, 32'd0);
    chk("rstfill_ihit", {31'd0, ihit}, 32'd0);
    iwait = 1'b0;
    iload = 32'hBAD0_0080;
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    @(posedge CLK); #1;
    nRST  = 1'b1;
    iwait = 1'b1;
    fetch(32'h0000_0080, 1, 32'h4444_0080);
    fetch(32'h0000_0004, 0, memval(32'h4));

    // Random fetches over a small address window to exercise aliasing,
    // with random offset bits, wait lengths and idle cycles.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        imemREN  = 1'b0;
        imemaddr = $urandom;
        @(negedge CLK);
        chk("rnd_idle_ihit", {31'd0, ihit}, 32'd0);
        chk("rnd_idle_load", imemload, 32'd0);
        @(posedge CLK); #1;
      end
      a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
        | 32'($urandom_range(0, 3));
      fetch(a, int'($urandom_range(0, 3)), memval({a[31:2], 2'b00}));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, one-word-per-frame instruction cache.
- Sits between the pipelined datapath's fetch port (imemREN/imemaddr/ihit/imemload) and the memory controller's instruction port (iREN/iaddr/iwait/iload).
- Serves fetches in one cycle on a hit.
- On a miss, runs a single-word fill from memory and stalls fetch (ihit low) until the frame is valid.

Parameters:
- IDX_W, 4, index bits; frame count = 2**IDX_W (16).
- TAG_W, 26, tag bits; must equal 32 - IDX_W - 2.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- imemREN  in  1  datapath fetch request
- imemaddr  in  32  fetch byte address; bits [1:0] ignored
- ihit  out  1  fetch data valid this cycle
- imemload  out  32  fetched instruction
- iREN  out  1  read request to memory controller
- iaddr  out  32  word-aligned fill address
- iwait  in  1  memory busy; low means iload valid this cycle
- iload  in  32  fill data from memory

Behaviour:
- Address split:
  - tag = imemaddr[31:32-TAG_W]
  - index = imemaddr[IDX_W+1:2]
  - offset [1:0] unused
- Storage per frame: valid (1), tag (TAG_W), data (32). All valid bits are flop-based and cleared on reset; tag/data need no reset.
- Reset (nRST low, async): all valid=0, state=IDLE, miss_addr=0. ihit=0, iREN=0, iaddr=0, imemload=0 while in reset.
- FSM states: IDLE, FILL.
- IDLE:
  - hit = imemREN & valid[index] & (tag[index]==tag).
  - ihit=hit and imemload=data[index], combinational, same cycle.
  - On imemREN & ~hit: capture miss_addr={imemaddr[31:2],2'b00} and go to FILL. ihit=0 this cycle.
  - imemREN=0: ihit=0, imemload=0, no state change.
- FILL:
  - iREN=1, iaddr=miss_addr, held stable every FILL cycle; ihit=0.
  - When iwait=0: write data=iload, tag and valid=1 into frame miss_addr's index at the rising edge, then return to IDLE.
  - No bypass: the hit is seen in IDLE the next cycle.
- Latency:
  - Hit: 0 cycles (combinational).
  - Miss with memory asserting iwait for N cycles then dropping: ihit rises N+2 cycles after the miss is detected (1 cycle to enter FILL, N wait cycles, 1 completion cycle, then IDLE hit).
- Outside FILL: iREN=0 and iaddr=0.
- imemaddr changes during FILL (branch redirect/flush): the fill completes to miss_addr regardless. IDLE then re-evaluates the new address and may start a new miss. No abort.
- imemREN drops during FILL: the fill still completes.
- Aliasing: two addresses with the same index and different tags evict each other. The last fill wins; no replacement state.
- Reset asserted mid-FILL: the in-progress fill is discarded and no frame is written. Return to IDLE with all frames invalid; iREN drops asynchronously.
- No write path. Self-modifying code is unsupported; the datapath halt does not flush.

Decomposition:
- cpu_types_pkg holds:
  - icache_frame_t struct {valid, tag[TAG_W], data word_t}
  - constants ICACHE_IDX_W=4 and ICACHE_TAG_W=26
  - enum icache_state_t {IDLE, FILL}
- The frame array and FSM live in one module; no sub-module is needed.

Test Plan:
- Reset then imemREN=1, imemaddr=0x00000000, memory returns 0x3C010001 after iwait high for 2 cycles:
  - iREN=1 and iaddr=0x0 for 3 cycles.
  - ihit=1 with imemload=0x3C010001 on the 5th cycle after the request.
- Re-fetch 0x00000000 immediately: ihit=1 same cycle, iREN stays 0.
- Alias: fetch 0x00000040 (same index 0, tag differs). Expect miss and fill with 0xDEADBEEF. A later fetch of 0x00000000 misses again (iREN=1, iaddr=0x0).
- Fill 16 sequential words 0x0..0x3C, then re-read all: 16 consecutive ihit=1 cycles, iREN never asserted.
- During FILL of 0x100, change imemaddr to 0x200 while iwait high:
  - iaddr stays 0x100 and frame 0 is written with the 0x100 tag.
  - The next cycle starts a miss with iaddr=0x200.
- Assert nRST low mid-FILL: iREN drops immediately. After release, a fetch of the same address misses (frame not written).
